// File: rtl/poly_mult_pkg.sv
// Shared types and tile-count helpers for the tiled polynomial multiplier.
package poly_mult_pkg;

   typedef enum logic [2:0] {
      IDLE, CLEAR, ISSUE, DRAIN, WAIT_LOADER, DONE
   } sched_state_t;

   function automatic int tiles_a(input int poly_a_width, input int poly_a_tile_width);
      return poly_a_width / poly_a_tile_width;
   endfunction

   function automatic int tiles_b(input int poly_b_width, input int poly_b_tile_width);
      return poly_b_width / poly_b_tile_width;
   endfunction

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_valid_pipe.sv
// Shift register of {valid, tile index} matching the coefficient memory read latency.
module tile_valid_pipe #(
   parameter int DEPTH = 2,
   parameter int IW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [IW-1:0] in_index,
   output logic          out_valid,
   output logic [IW-1:0] out_index,
   output logic          empty
);

   logic [DEPTH-1:0]         vld_pipe;
   logic [DEPTH-1:0][IW-1:0] idx_pipe;

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_pipe <= '0;
         idx_pipe <= '0;
      end else begin
         for (int i = DEPTH-1; i > 0; i--) begin
            vld_pipe[i] <= vld_pipe[i-1];
            idx_pipe[i] <= idx_pipe[i-1];
         end
         vld_pipe[0] <= in_valid;
         // Index is zeroed on bubbles so tile_index idles at 0.
         idx_pipe[0] <= in_valid ? in_index : '0;
      end
   end

   assign out_valid = vld_pipe[DEPTH-1];
   assign out_index = idx_pipe[DEPTH-1];
   assign empty     = ~|vld_pipe;

endmodule

// File: rtl/poly_tile_scheduler.sv
// Walks all (A tile, B tile) pairs for one C = A*B job, B outer / A inner.
// Optional perf counters enabled by defining SCHED_PERF_CNT_EN.
module poly_tile_scheduler
   import poly_mult_pkg::*;
#(
   parameter int POLY_A_WIDTH      = 128,
   parameter int POLY_B_WIDTH      = 128,
   parameter int POLY_A_TILE_WIDTH = 8,
   parameter int POLY_B_TILE_WIDTH = 8,
   parameter int MEM_LATENCY       = 2,
   localparam int NA = tiles_a(POLY_A_WIDTH, POLY_A_TILE_WIDTH),
   localparam int NB = tiles_b(POLY_B_WIDTH, POLY_B_TILE_WIDTH),
   localparam int NT = NA * NB,
   localparam int AW = clog2_min1(NA),
   localparam int BW = clog2_min1(NB),
   localparam int TW = $clog2(NT) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mult_stall,
   input  logic          loader_done,
   output logic          loader_rst_n,
   output logic          a_rd_en,
   output logic [AW-1:0] a_rd_addr,
   output logic          b_rd_en,
   output logic [BW-1:0] b_rd_addr,
   output logic          tile_valid,
   output logic [TW-1:0] tile_index,
   output logic          busy,
   output logic          done
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [31:0]   perf_cycles,
   output logic [31:0]   perf_stall
`endif
);

   sched_state_t  state, state_nxt;
   logic [AW-1:0] a_idx;
   logic [BW-1:0] b_idx;
   logic [TW-1:0] t_idx;
   logic          issue;
   logic          pipe_empty;

   always_comb begin
      state_nxt    = state;
      issue        = 1'b0;
      loader_rst_n = 1'b1;
      busy         = (state != IDLE);
      done         = 1'b0;
      case (state)
         IDLE:        if (start) state_nxt = CLEAR;
         CLEAR: begin
            loader_rst_n = 1'b0;
            state_nxt    = ISSUE;
         end
         ISSUE: begin
            issue = !mult_stall;
            if (issue && t_idx == TW'(NT-1)) state_nxt = DRAIN;
         end
         DRAIN:       if (pipe_empty) state_nxt = WAIT_LOADER;
         WAIT_LOADER: if (loader_done) state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default:     state_nxt = IDLE;
      endcase
   end

   // Issue count equals b*NA+a because A is the inner loop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         a_idx <= '0;
         b_idx <= '0;
         t_idx <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) begin
            a_idx <= '0;
            b_idx <= '0;
            t_idx <= '0;
         end else if (issue) begin
            t_idx <= t_idx + 1'b1;
            if (a_idx == AW'(NA-1)) begin
               a_idx <= '0;
               b_idx <= (b_idx == BW'(NB-1)) ? '0 : b_idx + 1'b1;
            end else begin
               a_idx <= a_idx + 1'b1;
            end
         end
      end
   end

   assign a_rd_en   = issue;
   assign b_rd_en   = issue;
   assign a_rd_addr = a_idx;
   assign b_rd_addr = b_idx;

   tile_valid_pipe #(.DEPTH(MEM_LATENCY), .IW(TW)) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (issue),
      .in_index  (t_idx),
      .out_valid (tile_valid),
      .out_index (tile_index),
      .empty     (pipe_empty)
   );

`ifdef SCHED_PERF_CNT_EN
   // CLEAR loads 1 so the CLEAR cycle itself is counted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else if (state == CLEAR) begin
         perf_cycles <= 32'd1;
         perf_stall  <= '0;
      end else if (state != IDLE) begin
         if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
         if (state == ISSUE && mult_stall && perf_stall != '1)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_poly_tile_scheduler.sv
// Bench for poly_tile_scheduler: timeline table, corner sequences, randomized stall run.
module tb_poly_tile_scheduler;

   localparam int NT2 = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       s1_start, s1_stall, s1_ldone, s1_lrst, s1_rda, s1_rdb, s1_tv, s1_busy, s1_done;
   logic [1:0] s1_a, s1_b;
   logic [4:0] s1_ti;
   logic       s2_start, s2_stall, s2_ldone, s2_lrst, s2_rda, s2_rdb, s2_tv, s2_busy, s2_done;
   logic [3:0] s2_a, s2_b;
   logic [8:0] s2_ti;
`ifdef SCHED_PERF_CNT_EN
   logic [31:0] p1_cyc, p1_stall, p2_cyc, p2_stall;
`endif

   poly_tile_scheduler #(
      .POLY_A_WIDTH(32), .POLY_B_WIDTH(32), .POLY_A_TILE_WIDTH(8), .POLY_B_TILE_WIDTH(8),
      .MEM_LATENCY(2)
   ) dut (
      .clk(clk), .rst(rst), .start(s1_start), .mult_stall(s1_stall), .loader_done(s1_ldone),
      .loader_rst_n(s1_lrst), .a_rd_en(s1_rda), .a_rd_addr(s1_a), .b_rd_en(s1_rdb),
      .b_rd_addr(s1_b), .tile_valid(s1_tv), .tile_index(s1_ti), .busy(s1_busy), .done(s1_done)
`ifdef SCHED_PERF_CNT_EN
      , .perf_cycles(p1_cyc), .perf_stall(p1_stall)
`endif
   );

   poly_tile_scheduler #(.MEM_LATENCY(1)) dut2 (
      .clk(clk), .rst(rst), .start(s2_start), .mult_stall(s2_stall), .loader_done(s2_ldone),
      .loader_rst_n(s2_lrst), .a_rd_en(s2_rda), .a_rd_addr(s2_a), .b_rd_en(s2_rdb),
      .b_rd_addr(s2_b), .tile_valid(s2_tv), .tile_index(s2_ti), .busy(s2_busy), .done(s2_done)
`ifdef SCHED_PERF_CNT_EN
      , .perf_cycles(p2_cyc), .perf_stall(p2_stall)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic start; logic ldone;
      logic lrst;  logic rd; logic tv; logic busy; logic done;
      int a; int b; int ti;
   } vec_t;
   vec_t tab [26];

   function automatic bit s2_rd_exp(int c);
      return c >= 2 && c <= 20 && !(c >= 5 && c <= 7);
   endfunction

   int hist_rd [4096];
   int hist_n  [4096];

   initial begin
      int cnt, last_rd, done_c, n, ldc, k;
      bit exp_rd, exp_tv, fin;

      rst = 1'b0;
      s1_start = 0; s1_stall = 0; s1_ldone = 0;
      s2_start = 0; s2_stall = 0; s2_ldone = 0;

      // Timeline for an unstalled 4x4 job, straight from the cycle plan.
      for (int c = 0; c < 26; c++) begin
         tab[c].start = (c == 0);
         tab[c].ldone = (c == 22);
         tab[c].lrst  = (c != 1);
         tab[c].rd    = (c >= 2 && c <= 17);
         tab[c].tv    = (c >= 4 && c <= 19);
         tab[c].busy  = (c >= 1 && c <= 23);
         tab[c].done  = (c == 23);
         tab[c].a     = (c - 2) % 4;
         tab[c].b     = (c - 2) / 4;
         tab[c].ti    = c - 4;
      end

      repeat (2) @(negedge clk);
      #1;
      chk("rst_rd", s1_rda, 0);   chk("rst_tv", s1_tv, 0);   chk("rst_busy", s1_busy, 0);
      chk("rst_done", s1_done, 0); chk("rst_lrst", s1_lrst, 1); chk("rst_a", s1_a, 0);
      chk("rst_b", s1_b, 0);       chk("rst_ti", s1_ti, 0);   chk("rst2_busy", s2_busy, 0);
      rst = 1'b1;

      // Scenario 1: table-driven.
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         s1_start = tab[c].start; s1_ldone = tab[c].ldone; s1_stall = 0;
         #1;
         chk($sformatf("s1_lrst c%0d", c), s1_lrst, tab[c].lrst);
         chk($sformatf("s1_rd c%0d", c),   s1_rda,  tab[c].rd);
         chk($sformatf("s1_rdb c%0d", c),  s1_rdb,  tab[c].rd);
         chk($sformatf("s1_tv c%0d", c),   s1_tv,   tab[c].tv);
         chk($sformatf("s1_busy c%0d", c), s1_busy, tab[c].busy);
         chk($sformatf("s1_done c%0d", c), s1_done, tab[c].done);
         if (tab[c].rd) begin
            chk($sformatf("s1_a c%0d", c), s1_a, tab[c].a);
            chk($sformatf("s1_b c%0d", c), s1_b, tab[c].b);
         end
         if (tab[c].tv) chk($sformatf("s1_ti c%0d", c), s1_ti, tab[c].ti);
      end
`ifdef SCHED_PERF_CNT_EN
      chk("s1_perf_cycles", p1_cyc, 23);
      chk("s1_perf_stall", p1_stall, 0);
`endif

      // Scenario 2: stall on cycles 5..7, start held across DONE relaunches.
      cnt = 0; last_rd = -1; done_c = -1;
      for (int c = 0; c < 29; c++) begin
         @(negedge clk);
         s1_start = (c == 0) || (c >= 25 && c <= 27);
         s1_stall = (c >= 5 && c <= 7);
         s1_ldone = (c == 25);
         #1;
         chk($sformatf("s2_rd c%0d", c), s1_rda, s2_rd_exp(c));
         chk($sformatf("s2_tv c%0d", c), s1_tv, s2_rd_exp(c - 2));
         if (s1_rda) last_rd = c;
         if (s1_tv) begin
            chk($sformatf("s2_ti c%0d", c), s1_ti, cnt);
            cnt++;
         end
         if (s1_done) done_c = c;
         if (c == 8) begin
            chk("s2_resume_a", s1_a, 3);
            chk("s2_resume_b", s1_b, 0);
         end
         if (c == 27) chk("s2_idle_busy", s1_busy, 0);
         if (c == 28) chk("s2_relaunch_lrst", s1_lrst, 0);
`ifdef SCHED_PERF_CNT_EN
         if (c == 27) chk("s2_perf_stall", p1_stall, 3);
`endif
      end
      chk("s2_tv_count", cnt, 16);
      chk("s2_last_rd", last_rd, 20);
      chk("s2_done_cycle", done_c, 26);
      @(negedge clk); rst = 1'b0; s1_start = 0; s1_ldone = 0; s1_stall = 0;
      @(negedge clk); rst = 1'b1;

      // Scenario 3: start in ISSUE/DRAIN ignored, relaunch from IDLE, reset mid-job.
      for (int c = 0; c < 51; c++) begin
         @(negedge clk);
         s1_start = (c == 0) || (c == 8) || (c == 19) || (c == 31);
         s1_ldone = (c == 22);
         rst = (c != 41);
         #1;
         chk($sformatf("s3_rd c%0d", c), s1_rda, (c >= 2 && c <= 17) || (c >= 33 && c <= 41));
         chk($sformatf("s3_tv c%0d", c), s1_tv, (c >= 4 && c <= 19) || (c >= 35 && c <= 41));
         chk($sformatf("s3_busy c%0d", c), s1_busy, (c >= 1 && c <= 23) || (c >= 32 && c <= 41));
         chk($sformatf("s3_done c%0d", c), s1_done, c == 23);
         chk($sformatf("s3_lrst c%0d", c), s1_lrst, !(c == 1 || c == 32));
         if (s1_tv) chk($sformatf("s3_ti c%0d", c), s1_ti, (c < 20) ? c - 4 : c - 35);
         if (c == 42) begin
            chk("s3_rst_a", s1_a, 0);
            chk("s3_rst_b", s1_b, 0);
            chk("s3_rst_ti", s1_ti, 0);
         end
      end
      s1_start = 0; s1_ldone = 0;

      // Scenario 4: 16x16 tiles, latency 1, random stalls against a counting model.
      n = 0; ldc = -1; fin = 0; k = $urandom_range(0, 3);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         s2_start = (c == 0);
         s2_stall = (c >= 2) && ($urandom_range(0, 9) < 3);
         s2_ldone = (ldc >= 0 && c == ldc);
         #1;
         exp_rd = (c >= 2 && n < NT2 && !s2_stall);
         chk($sformatf("s4_rd c%0d", c), s2_rda, exp_rd);
         chk($sformatf("s4_rdb c%0d", c), s2_rdb, exp_rd);
         if (exp_rd) begin
            chk($sformatf("s4_a c%0d", c), s2_a, n % 16);
            chk($sformatf("s4_b c%0d", c), s2_b, n / 16);
         end
         hist_rd[c] = exp_rd;
         hist_n[c]  = n;
         if (exp_rd) begin
            n++;
            if (n == NT2) ldc = c + 3 + k;
         end
         exp_tv = (c >= 1) ? hist_rd[c-1] != 0 : 1'b0;
         chk($sformatf("s4_tv c%0d", c), s2_tv, exp_tv);
         if (exp_tv) chk($sformatf("s4_ti c%0d", c), s2_ti, hist_n[c-1]);
         chk($sformatf("s4_done c%0d", c), s2_done, ldc >= 0 && c == ldc + 1);
         chk($sformatf("s4_busy c%0d", c), s2_busy, c >= 1 && (ldc < 0 || c <= ldc + 1));
         if (ldc >= 0 && c == ldc + 3) begin
            fin = 1;
            break;
         end
      end
      chk("s4_finished", fin, 1);
      chk("s4_issue_count", n, NT2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
